mul_iter_64: RTL and testbench

- Iterative 64x64->128 shift-add multiplier for the ARMv8 datapath. Serves MUL (low half) and UMULH/SMULH (high half).
- Sits downstream of the 64-bit carry-lookahead adder and consumes its Sum/Cout every cycle. The adder performs each partial-product accumulation and the signed-correction subtractions.
- Single request/done handshake toward the execute stage. Operands are latched on start.

---
 rtl/mul_iter_64_pkg.sv | 20 ++
 rtl/mul_iter_64_cla.sv | 59 +++++
 rtl/mul_iter_64.sv | 163 ++++++++++++++++
 tb/tb_mul_iter_64.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_iter_64_pkg.sv
// mul_iter_64_pkg
//   Shared definitions for the iterative 64x64->128 multiplier:
//   FSM state encoding, operand width, iteration-counter width and
//   the index of the final shift-add iteration.
//   No ports (package).
package mul_iter_64_pkg;

  localparam int WIDTH     = 64;
  localparam int CNT_W     = 7;
  localparam int ITER_LAST = 63;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MUL    = 3'd1,
    ST_CORR_A = 3'd2,
    ST_CORR_B = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/mul_iter_64_cla.sv
// mul_iter_64_cla
//   The 64-bit carry-lookahead adder (CLA_64bit) used by the multiplier
//   for every partial-product accumulation and signed correction.
//   Built from sixteen 4-bit lookahead groups; the group generate and
//   propagate terms feed a second-level carry chain across the groups.
// Ports:
//   A, B  : 64-bit addends
//   Cin   : carry in
//   Sum   : 64-bit sum
//   Cout  : carry out of bit 63
module mul_iter_64_cla
  import mul_iter_64_pkg::*;
(
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int GROUPS = WIDTH / 4;

  logic [WIDTH-1:0]  g;
  logic [WIDTH-1:0]  p;
  logic [WIDTH-1:0]  c;
  logic [GROUPS-1:0] gg;
  logic [GROUPS-1:0] gp;
  logic [GROUPS:0]   gc;

  always_comb begin
    g  = A & B;
    p  = A ^ B;
    c  = '0;
    gg = '0;
    gp = '0;
    gc = '0;
    gc[0] = Cin;
    for (int j = 0; j < GROUPS; j++) begin
      // Group generate / propagate over bits 4j..4j+3
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
      // Per-bit carries inside the group, all looked ahead from the group carry-in
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    Sum  = p ^ c;
    Cout = gc[GROUPS];
  end

endmodule

// File: rtl/mul_iter_64.sv
// mul_iter_64
//   Iterative 64x64->128 shift-add multiplier. Serves MUL (low half) and
//   UMULH/SMULH (high half). One partial product is accumulated per clock
//   through the shared CLA; signed results apply two subtraction
//   corrections to the high half after the 64 unsigned iterations.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : request, accepted only in IDLE or DONE
//   is_signed : 1 = two's-complement operands, latched on accept
//   a, b      : multiplicand / multiplier, latched on accept
//   busy      : high from accept until the last iteration/correction
//   done      : one-cycle pulse, product valid in this cycle
//   prod_hi   : product bits 127:64
//   prod_lo   : product bits 63:0
//
// Handshake: a request is taken at a rising edge where start=1 and the
// FSM is in IDLE or DONE; start is ignored otherwise. busy is high in
// every cycle after the accept edge up to the final working edge; done is
// high for exactly one cycle afterwards, with busy low, and the product is
// valid in that cycle. Asserting start during the done cycle launches the
// next operation without an idle cycle.
module mul_iter_64
  import mul_iter_64_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] b_orig;   // lo is shifted away, so b is kept for CORR_B/CORR_A
  logic             sgn;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  logic             accept;

  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  // Adder operand selection. Corrections always drive the adder, with a
  // zero addend when no subtraction is needed, so latency never varies.
  always_comb begin
    add_a   = hi;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      ST_MUL: begin
        add_b = lo[0] ? mcand : '0;
      end
      ST_CORR_A: begin
        // negative a: subtract b from the high half
        if (mcand[WIDTH-1]) begin
          add_b   = ~b_orig;
          add_cin = 1'b1;
        end
      end
      ST_CORR_B: begin
        // negative b: subtract a from the high half
        if (b_orig[WIDTH-1]) begin
          add_b   = ~mcand;
          add_cin = 1'b1;
        end
      end
      default: begin
        add_b   = '0;
        add_cin = 1'b0;
      end
    endcase
  end

  mul_iter_64_cla u_cla (
    .A    (add_a),
    .B    (add_b),
    .Cin  (add_cin),
    .Sum  (sum),
    .Cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      b_orig <= '0;
      sgn    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (accept) begin
            mcand  <= a;
            b_orig <= b;
            sgn    <= is_signed;
            hi     <= '0;
            lo     <= b;
            count  <= '0;
            busy   <= 1'b1;
            state  <= ST_MUL;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          // {hi,lo} <= {cout, sum, lo} >> 1
          hi    <= {cout, sum[WIDTH-1:1]};
          lo    <= {sum[0], lo[WIDTH-1:1]};
          count <= count + CNT_W'(1);
          if (count == CNT_W'(ITER_LAST)) begin
            if (sgn) begin
              state <= ST_CORR_A;
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_CORR_A: begin
          hi    <= sum;   // carry-out dropped: result is modulo 2^64
          state <= ST_CORR_B;
        end
        ST_CORR_B: begin
          hi    <= sum;
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // The accumulator only moves while an operation runs, so the product
  // outputs hold in IDLE and follow the accumulator once a request is taken.
  assign prod_hi = hi;
  assign prod_lo = lo;

endmodule

// File: tb/tb_mul_iter_64.sv
// tb_mul_iter_64
//   Directed bench for mul_iter_64: a driver issues requests and pushes the
//   hand-computed product and the expected done cycle into queues; a monitor
//   pops and compares whenever done is high.
module tb_mul_iter_64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        busy;
  logic        done;
  logic [63:0] prod_hi;
  logic [63:0] prod_lo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [127:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [127:0] mon_exp;
  int           mon_cyc;

  mul_iter_64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .prod_hi   (prod_hi),
    .prod_lo   (prod_lo)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending request", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("product", {prod_hi, prod_lo}, mon_exp);
        check("done_cycle", 128'(cyc), 128'(mon_cyc));
        check("busy_at_done", 128'(busy), 128'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; the request is accepted at the next
  // rising edge. lat is the number of edges from accept to done.
  task automatic issue(input logic [63:0] ta, input logic [63:0] tb_v, input logic sg,
                       input logic [63:0] eh, input logic [63:0] el, input int lat);
    a = ta;
    b = tb_v;
    is_signed = sg;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({eh, el});
    exp_cyc_q.push_back(cyc + lat);
    start = 1'b0;
    // operand changes while busy must not matter
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    is_signed = 1'($urandom_range(0, 1));
  endtask

  // Returns at the falling edge where done is high; counts busy cycles seen.
  task automatic wait_done(output int nb);
    int k;
    nb = 0;
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (done) break;
      if (busy) nb++;
      k++;
    end
    if (k >= 200) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", k);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nb;

    // asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_prod_hi", 128'(prod_hi), 128'(0));
    check("rst_prod_lo", 128'(prod_lo), 128'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 3 * 5 unsigned
    issue(64'd3, 64'd5, 1'b0, 64'd0, 64'd15, 64);
    wait_done(nb);
    check("busy_cycles_unsigned", 128'(nb), 128'(64));
    @(negedge clk);

    // max * max unsigned
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001, 64);
    wait_done(nb);
    @(negedge clk);

    // -1 * 2 signed
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    wait_done(nb);
    check("busy_cycles_signed", 128'(nb), 128'(66));
    @(negedge clk);

    // same operands unsigned
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0,
          64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64);
    wait_done(nb);
    @(negedge clk);

    // -3 * -5 signed: both corrections applied
    issue(64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1,
          64'd0, 64'd15, 66);
    wait_done(nb);
    @(negedge clk);

    // 5 * -7 signed: only the b correction applies
    issue(64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFDD, 66);
    wait_done(nb);
    @(negedge clk);

    // 7 * 6 with a second start while busy, which must be ignored
    issue(64'd7, 64'd6, 1'b0, 64'd0, 64'd42, 64);
    repeat (10) @(negedge clk);
    a = 64'd9;
    b = 64'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_ignored_start", 128'(busy), 128'(1));
    wait_done(nb);
    @(negedge clk);

    // asynchronous reset in the middle of an operation
    issue(64'd5, 64'd7, 1'b0, 64'd0, 64'd35, 64);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midop_rst_busy", 128'(busy), 128'(0));
    check("midop_rst_done", 128'(done), 128'(0));
    check("midop_rst_prod_hi", 128'(prod_hi), 128'(0));
    check("midop_rst_prod_lo", 128'(prod_lo), 128'(0));
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(64'd2, 64'd4, 1'b0, 64'd0, 64'd8, 64);
    wait_done(nb);
    @(negedge clk);

    // back-to-back: new request taken in the done cycle
    issue(64'd11, 64'd13, 1'b0, 64'd0, 64'd143, 64);
    wait_done(nb);
    issue(64'd10, 64'd10, 1'b0, 64'd0, 64'd100, 64);
    check("b2b_busy", 128'(busy), 128'(1));
    check("b2b_done_low", 128'(done), 128'(0));
    wait_done(nb);
    check("busy_cycles_b2b", 128'(nb), 128'(64));
    @(negedge clk);

    repeat (3) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
